// File: rtl/parity_frame_checker.sv
// Serial even/odd parity checker: DATA_W data bits (MSB first) then one parity bit.
// Optional saturating error counter and err_cnt port compiled in with PARITY_ERR_CNT_EN.
module parity_frame_checker #(
   parameter int DATA_W = 4,
   parameter int ODD    = 0,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] data_out
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0]  err_cnt
`endif
);

   localparam int            CW    = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST  = CW'(DATA_W - 1);
   localparam logic          ODD_B = (ODD != 0);

   typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] sr;
   logic [DATA_W:0]   sr_shift;
   logic              acc;
   logic [CW-1:0]     cnt;
   logic              accept;
   logic              perr;

`ifdef PARITY_ERR_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
`endif

   // flush has priority over an accompanying bit
   assign accept   = bit_valid & ~flush;
   assign sr_shift = {sr, bit_in};
   assign perr     = acc ^ bit_in ^ ODD_B;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else if (bit_valid) begin
         case (state)
            IDLE:    state_n = (DATA_W == 1) ? PAR : DATA;
            DATA:    if (cnt == LAST) state_n = PAR;
            PAR:     state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr       <= '0;
         acc      <= 1'b0;
         cnt      <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         data_out <= '0;
`ifdef PARITY_ERR_CNT_EN
         err_cnt  <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (flush) begin
            acc <= 1'b0;
            cnt <= '0;
         end else if (accept) begin
            case (state)
               IDLE: begin
                  sr  <= sr_shift[DATA_W-1:0];
                  acc <= bit_in;
                  cnt <= CW'(1);
               end
               DATA: begin
                  sr  <= sr_shift[DATA_W-1:0];
                  acc <= acc ^ bit_in;
                  cnt <= cnt + 1'b1;
               end
               PAR: begin
                  err      <= perr;
                  data_out <= sr;
                  done     <= 1'b1;
`ifdef PARITY_ERR_CNT_EN
                  if (perr) err_cnt <= sat_inc(err_cnt);
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: an even-parity and an odd-parity instance share one
// input stream; a queue-based frame model is compared every cycle, plus literal checks.
module tb_parity_frame_checker;

   localparam int DATA_W = 4;
   localparam int MAX_A  = 3;
   localparam int MAX_B  = 255;

   logic clk, rst, bit_in, bit_valid, flush;
   logic busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [DATA_W-1:0] data_a, data_b;
`ifdef PARITY_ERR_CNT_EN
   logic [1:0] ecnt_a;
   logic [7:0] ecnt_b;
`endif

   int checks = 0;
   int errors = 0;

   parity_frame_checker #(.DATA_W(DATA_W), .ODD(0), .CNT_W(2)) dut_a (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
      .busy(busy_a), .done(done_a), .err(err_a), .data_out(data_a)
`ifdef PARITY_ERR_CNT_EN
      , .err_cnt(ecnt_a)
`endif
   );

   parity_frame_checker #(.DATA_W(DATA_W), .ODD(1), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
      .busy(busy_b), .done(done_b), .err(err_b), .data_out(data_b)
`ifdef PARITY_ERR_CNT_EN
      , .err_cnt(ecnt_b)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: collect bits, decide on the (DATA_W+1)th accepted bit.
   bit               q[$];
   bit               chk_en = 1'b0;
   bit               exp_done = 1'b0, exp_err_a = 1'b0, exp_err_b = 1'b0;
   logic [DATA_W-1:0] exp_data = '0;
   int               cnt_a = 0, cnt_b = 0;

   always @(posedge clk) begin
      bit               x;
      logic [DATA_W-1:0] d;
      exp_done = 1'b0;
      if (rst) begin
         q.delete();
         exp_err_a = 1'b0;
         exp_err_b = 1'b0;
         exp_data  = '0;
         cnt_a     = 0;
         cnt_b     = 0;
         chk_en    = 1'b1;
      end else if (flush) begin
         q.delete();
      end else if (bit_valid) begin
         if (q.size() == DATA_W) begin
            x = bit_in;
            d = '0;
            foreach (q[i]) begin
               d = (d << 1) | DATA_W'(q[i]);
               x = x ^ q[i];
            end
            exp_data  = d;
            exp_err_a = x;
            exp_err_b = ~x;
            exp_done  = 1'b1;
            if (x && cnt_a < MAX_A) cnt_a++;
            if (!x && cnt_b < MAX_B) cnt_b++;
            q.delete();
         end else begin
            q.push_back(bit_in);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy_a", busy_a, q.size() != 0);
         chk("busy_b", busy_b, q.size() != 0);
         chk("done_a", done_a, exp_done);
         chk("done_b", done_b, exp_done);
         chk("err_a", err_a, exp_err_a);
         chk("err_b", err_b, exp_err_b);
         chk("data_a", data_a, exp_data);
         chk("data_b", data_b, exp_data);
`ifdef PARITY_ERR_CNT_EN
         chk("ecnt_a", ecnt_a, cnt_a);
         chk("ecnt_b", ecnt_b, cnt_b);
`endif
      end
   end

   task automatic cyc(input logic v, input logic b, input logic f);
      @(negedge clk);
      bit_valid = v;
      bit_in    = b;
      flush     = f;
   endtask

   task automatic frame(input logic [DATA_W:0] f);
      for (int i = DATA_W; i >= 0; i--) cyc(1'b1, f[i], 1'b0);
   endtask

   task automatic frame_gaps(input logic [DATA_W:0] f);
      for (int i = DATA_W; i >= 0; i--) begin
         repeat ($urandom_range(0, 5)) cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b1, f[i], 1'b0);
      end
   endtask

   // advance to the cycle after the parity edge and settle
   task automatic settle();
      cyc(1'b0, 1'b0, 1'b0);
      #1;
   endtask

   initial begin
      rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_err", err_a, 1'b0);
      chk("rst_data", data_a, 4'h0);

      frame(5'b1011_1);
      settle();
      chk("f1_done", done_a, 1'b1);
      chk("f1_data", data_a, 4'hB);
      chk("f1_err_even", err_a, 1'b0);
      chk("f1_err_odd", err_b, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      #1;
      chk("f1_done_drop", done_a, 1'b0);

      frame(5'b1011_0);
      settle();
      chk("f2_err_even", err_a, 1'b1);
`ifdef PARITY_ERR_CNT_EN
      chk("f2_cnt", ecnt_a, 2'd1);
`endif
      frame(5'b1011_1);
      settle();
      chk("f3_err_even", err_a, 1'b0);
`ifdef PARITY_ERR_CNT_EN
      chk("f3_cnt_hold", ecnt_a, 2'd1);
`endif

      frame(5'b0000_1);
      settle();
      chk("f4_err_odd", err_b, 1'b0);
      frame(5'b0000_0);
      settle();
      chk("f5_err_odd", err_b, 1'b1);

      // back-to-back frames with no bubble
      frame(5'b0101_0);
      frame(5'b1110_1);
      settle();
      chk("b2b_data", data_a, 4'hE);

      frame_gaps(5'b1100_0);
      settle();
      chk("gap_data", data_a, 4'hC);
      chk("gap_err", err_a, 1'b0);

      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      frame(5'b0110_0);
      settle();
      chk("flush_data", data_a, 4'h6);
      chk("flush_err", err_a, 1'b0);

      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      frame(5'b0110_0);
      settle();
      chk("flushv_data", data_a, 4'h6);

      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      bit_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_busy", busy_a, 1'b0);
      chk("mrst_data", data_a, 4'h0);
      chk("mrst_err_odd", err_b, 1'b0);
      chk("mrst_done", done_a, 1'b0);

      for (int k = 0; k < 5; k++) begin
         frame(5'b1011_0);
         settle();
         chk("bad_err", err_a, 1'b1);
`ifdef PARITY_ERR_CNT_EN
         chk("bad_cnt", ecnt_a, (k < 3) ? k + 1 : 3);
`endif
      end

      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
